// File: rtl/dmem_store_checker_pkg.sv
// Shared types and width helpers for the data-memory store checker.
// The checker walks an ordered table of expected stores and reports pass/fail/timeout.
package mips_check_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PASS,
    FAIL,
    TOUT
  } check_state_t;

  localparam int SC_W   = 16;
  localparam int SC_MAX = (1 << SC_W) - 1;

  // Bits needed to count matched entries from 0 up to and including n.
  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dmem_store_checker_watchdog_counter.sv
// Cycle watchdog for the store checker: counts enabled cycles and flags the last allowed one.
// A TIMEOUT of zero removes the counter entirely and never expires.
module watchdog_counter #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = clk ^ reset ^ clr ^ en;
      assign expired       = 1'b0;
    end else begin : g_on
      localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      logic [CW-1:0] count;

      // Holds at TIMEOUT-1 so expired stays asserted until cleared.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          count <= '0;
        end else if (clr) begin
          count <= '0;
        end else if (en && !expired) begin
          count <= count + CW'(1);
        end
      end

      assign expired = (count == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/dmem_store_checker.sv
// Monitors the data-memory write port and matches stores in order against an expected table.
// Status (pass/fail/timeout) is registered and held until the next start or reset.
module dmem_store_checker
  import mips_check_pkg::*;
#(
  parameter int             AW       = 32,
  parameter int             DW       = 32,
  parameter int             N        = 4,
  parameter bit             STRICT   = 1'b1,
  parameter logic [AW-1:0]  IGN_BASE = AW'(80),
  parameter logic [AW-1:0]  IGN_MASK = {{(AW-2){1'b1}}, 2'b00},
  parameter int             TIMEOUT  = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     dmem_write,
  input  logic [AW-1:0]            dmem_addr,
  input  logic [DW-1:0]            dmem_write_data,
  input  logic [N*AW-1:0]          exp_addr,
  input  logic [N*DW-1:0]          exp_data,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timeout,
  output logic [$clog2(N+1)-1:0]   match_idx,
  output logic [15:0]              store_count,
  output logic [AW-1:0]            fail_addr,
  output logic [DW-1:0]            fail_data
);

  localparam int IDX_W = idx_w(N);

  check_state_t  state;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data;
  logic          ignored;
  logic          hit;
  logic          expired;

  watchdog_counter #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (start),
    .en      (state == RUN),
    .expired (expired)
  );

  // Select the entry currently awaited; an explicit mux avoids indexing past entry N-1.
  always_comb begin
    cur_addr = '0;
    cur_data = '0;
    for (int i = 0; i < N; i++) begin
      if (match_idx == IDX_W'(i)) begin
        cur_addr = exp_addr[i*AW +: AW];
        cur_data = exp_data[i*DW +: DW];
      end
    end
  end

  assign ignored = ((dmem_addr & IGN_MASK) == (IGN_BASE & IGN_MASK));
  assign hit     = (dmem_addr == cur_addr) && (dmem_write_data == cur_data);

  // Decision priority within RUN: match, then strict mismatch, then watchdog expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      match_idx   <= '0;
      store_count <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
    end else if (start) begin
      state       <= RUN;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      match_idx   <= '0;
      store_count <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
    end else if (state == RUN) begin
      if (dmem_write && (store_count != 16'(SC_MAX))) begin
        store_count <= store_count + 16'd1;
      end
      if (dmem_write && !ignored && hit) begin
        match_idx <= match_idx + IDX_W'(1);
        if (match_idx == IDX_W'(N - 1)) begin
          state <= PASS;
          done  <= 1'b1;
          pass  <= 1'b1;
        end
      end else if (dmem_write && !ignored && STRICT) begin
        state     <= FAIL;
        done      <= 1'b1;
        fail      <= 1'b1;
        fail_addr <= dmem_addr;
        fail_data <= dmem_write_data;
      end else if (expired) begin
        state   <= TOUT;
        done    <= 1'b1;
        fail    <= 1'b1;
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_store_checker.sv
// Directed bench for dmem_store_checker using four differently configured instances.
// Expected values are queued when stimulus is driven and popped when the outputs are sampled.
module tb_dmem_store_checker;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  st;
  logic [3:0]  wr;
  logic [31:0] addr;
  logic [31:0] data;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic        done1, pass1, fail1, tout1;
  logic        idx1;
  logic [15:0] cnt1;
  logic [31:0] faddr1, fdata1;

  logic        done3, pass3, fail3, tout3;
  logic [1:0]  idx3;
  logic [15:0] cnt3;
  logic [31:0] faddr3, fdata3;

  logic        done20, pass20, fail20, tout20;
  logic        idx20;
  logic [15:0] cnt20;
  logic [31:0] faddr20, fdata20;

  logic        done5, pass5, fail5, tout5;
  logic [1:0]  idx5;
  logic [15:0] cnt5;
  logic [31:0] faddr5, fdata5;

  always #5 clk = ~clk;

  dmem_store_checker #(.N(1), .STRICT(1'b1), .TIMEOUT(1000)) u1 (
    .clk(clk), .reset(reset), .start(st[0]), .dmem_write(wr[0]),
    .dmem_addr(addr), .dmem_write_data(data),
    .exp_addr(32'd84), .exp_data(32'd7),
    .done(done1), .pass(pass1), .fail(fail1), .timeout(tout1),
    .match_idx(idx1), .store_count(cnt1), .fail_addr(faddr1), .fail_data(fdata1)
  );

  dmem_store_checker #(.N(3), .STRICT(1'b0), .TIMEOUT(1000)) u3 (
    .clk(clk), .reset(reset), .start(st[1]), .dmem_write(wr[1]),
    .dmem_addr(addr), .dmem_write_data(data),
    .exp_addr({32'd8, 32'd4, 32'd0}), .exp_data({32'd3, 32'd2, 32'd1}),
    .done(done3), .pass(pass3), .fail(fail3), .timeout(tout3),
    .match_idx(idx3), .store_count(cnt3), .fail_addr(faddr3), .fail_data(fdata3)
  );

  dmem_store_checker #(.N(1), .STRICT(1'b1), .TIMEOUT(20)) u20 (
    .clk(clk), .reset(reset), .start(st[2]), .dmem_write(wr[2]),
    .dmem_addr(addr), .dmem_write_data(data),
    .exp_addr(32'd84), .exp_data(32'd7),
    .done(done20), .pass(pass20), .fail(fail20), .timeout(tout20),
    .match_idx(idx20), .store_count(cnt20), .fail_addr(faddr20), .fail_data(fdata20)
  );

  dmem_store_checker #(.N(2), .STRICT(1'b1), .TIMEOUT(5)) u5 (
    .clk(clk), .reset(reset), .start(st[3]), .dmem_write(wr[3]),
    .dmem_addr(addr), .dmem_write_data(data),
    .exp_addr({32'd4, 32'd0}), .exp_data({32'd2, 32'd1}),
    .done(done5), .pass(pass5), .fail(fail5), .timeout(tout5),
    .match_idx(idx5), .store_count(cnt5), .fail_addr(faddr5), .fail_data(fdata5)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic check_output(input logic [31:0] observed);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_empty: observed %0h required an expectation", observed);
    end else begin
      e = sb.pop_front();
      assert (observed === e.value) else begin
        errors++;
        $error("[TB] FAIL %s: observed %0h expected %0h", e.tag, observed, e.value);
      end
    end
  endtask

  // One-cycle start pulse on the selected instance.
  task automatic apply_start(input int which);
    st[which] = 1'b1;
    step();
    st[which] = 1'b0;
  endtask

  // One-cycle store on the selected instance.
  task automatic apply_stimulus(input int which, input logic [31:0] a, input logic [31:0] d);
    wr[which] = 1'b1;
    addr      = a;
    data      = d;
    step();
    wr[which] = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    st    = '0;
    wr    = '0;
    addr  = '0;
    data  = '0;
    step();
    step();
    push_exp("rst.done", 0);        check_output(32'(done1));
    push_exp("rst.pass", 0);        check_output(32'(pass1));
    push_exp("rst.fail", 0);        check_output(32'(fail1));
    push_exp("rst.store_count", 0); check_output(32'(cnt1));
    reset = 1'b0;
    step();

    $display("[TB] single store 7 at 84 after an ignored store");
    apply_start(0);
    push_exp("s1.count_after_ignored", 1);
    apply_stimulus(0, 32'd80, 32'hDEAD);
    check_output(32'(cnt1));
    push_exp("s1.pass_before_match", 0); check_output(32'(pass1));
    push_exp("s1.pass", 1);
    push_exp("s1.done", 1);
    push_exp("s1.fail", 0);
    push_exp("s1.match_idx", 1);
    push_exp("s1.store_count", 2);
    apply_stimulus(0, 32'd84, 32'd7);
    check_output(32'(pass1));
    check_output(32'(done1));
    check_output(32'(fail1));
    check_output(32'(idx1));
    check_output(32'(cnt1));
    push_exp("s1.count_frozen", 2);
    push_exp("s1.pass_held", 1);
    apply_stimulus(0, 32'd84, 32'd5);
    check_output(32'(cnt1));
    check_output(32'(pass1));

    $display("[TB] strict mismatch 5 at 84");
    push_exp("s2.start_clears_done", 0);
    push_exp("s2.start_clears_count", 0);
    apply_start(0);
    check_output(32'(done1));
    check_output(32'(cnt1));
    push_exp("s2.fail", 1);
    push_exp("s2.pass", 0);
    push_exp("s2.timeout", 0);
    push_exp("s2.fail_addr", 84);
    push_exp("s2.fail_data", 5);
    push_exp("s2.match_idx", 0);
    apply_stimulus(0, 32'd84, 32'd5);
    check_output(32'(fail1));
    check_output(32'(pass1));
    check_output(32'(tout1));
    check_output(faddr1);
    check_output(fdata1);
    check_output(32'(idx1));

    $display("[TB] lenient three-entry table with a skipped store");
    apply_start(1);
    apply_stimulus(1, 32'd0, 32'd1);
    push_exp("s3.skip_no_fail", 0);
    apply_stimulus(1, 32'd12, 32'd9);
    check_output(32'(fail3));
    push_exp("s3.idx_mid", 2);
    push_exp("s3.pass_mid", 0);
    apply_stimulus(1, 32'd4, 32'd2);
    check_output(32'(idx3));
    check_output(32'(pass3));
    push_exp("s3.pass", 1);
    push_exp("s3.match_idx", 3);
    push_exp("s3.store_count", 4);
    push_exp("s3.fail", 0);
    apply_stimulus(1, 32'd8, 32'd3);
    check_output(32'(pass3));
    check_output(32'(idx3));
    check_output(32'(cnt3));
    check_output(32'(fail3));

    $display("[TB] watchdog of 20 cycles with an idle bus");
    apply_start(2);
    for (int i = 0; i < 19; i++) begin
      push_exp("s4.timeout_early", 0);
      step();
      check_output(32'(tout20));
    end
    push_exp("s4.timeout", 1);
    push_exp("s4.fail", 1);
    push_exp("s4.done", 1);
    push_exp("s4.pass", 0);
    step();
    check_output(32'(tout20));
    check_output(32'(fail20));
    check_output(32'(done20));
    check_output(32'(pass20));
    push_exp("s4.restart_timeout", 0);
    push_exp("s4.restart_fail", 0);
    push_exp("s4.restart_done", 0);
    apply_start(2);
    check_output(32'(tout20));
    check_output(32'(fail20));
    check_output(32'(done20));
    push_exp("s4.rerun_pass", 1);
    apply_stimulus(2, 32'd84, 32'd7);
    check_output(32'(pass20));

    $display("[TB] final match on the last watchdog cycle");
    apply_start(3);
    step();
    step();
    step();
    apply_stimulus(3, 32'd0, 32'd1);
    push_exp("s5.pass", 1);
    push_exp("s5.timeout", 0);
    push_exp("s5.match_idx", 2);
    apply_stimulus(3, 32'd4, 32'd2);
    check_output(32'(pass5));
    check_output(32'(tout5));
    check_output(32'(idx5));

    $display("[TB] watchdog expiry with one entry still outstanding");
    apply_start(3);
    apply_stimulus(3, 32'd0, 32'd1);
    step();
    step();
    push_exp("s6.timeout_cycle4", 0);
    step();
    check_output(32'(tout5));
    push_exp("s6.timeout", 1);
    push_exp("s6.match_idx", 1);
    step();
    check_output(32'(tout5));
    check_output(32'(idx5));

    $display("[TB] asynchronous reset between edges");
    apply_start(0);
    push_exp("s7.count_before_reset", 1);
    apply_stimulus(0, 32'd80, 32'd1);
    check_output(32'(cnt1));
    reset = 1'b1;
    #2;
    push_exp("s7.count_reset", 0);
    push_exp("s7.other_pass_reset", 0);
    push_exp("s7.match_idx_reset", 0);
    check_output(32'(cnt1));
    check_output(32'(pass3));
    check_output(32'(idx5));
    reset = 1'b0;
    push_exp("s7.idle_pass", 0);
    push_exp("s7.idle_count", 0);
    apply_stimulus(0, 32'd84, 32'd7);
    check_output(32'(pass1));
    check_output(32'(cnt1));

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
